ahb_sram_slave: RTL and testbench

AHB slave that responds to bus transfers with an internal word-addressed memory. Supports byte, halfword and word accesses, a programmable number of wait states, and the two-cycle ERROR response for illegal transfers. Sits behind the decoder (`hsel`) and feeds the slave-side multiplexor (`hrdata`, `hready`, `hresp`).

---
 rtl/ahb_sram_slave_if.sv | 69 ++++++
 rtl/ahb_sram_slave.sv | 207 ++++++++++++++++++++
 tb/tb_ahb_sram_slave.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_sram_slave_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ahb_sram_pkg / ahb_sram_slave_if                        |
// | Description : AHB bus field types and the slave-side bus bundle      |
// |               (master and slave modports) for ahb_sram_slave.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+

package ahb_sram_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } ahb_trans_t;

  typedef enum logic [1:0] {
    HSIZE_BYTE  = 2'd0,
    HSIZE_HALF  = 2'd1,
    HSIZE_WORD  = 2'd2,
    HSIZE_DWORD = 2'd3
  } ahb_size_t;

  typedef logic [2:0] ahb_burst_t;
  typedef logic [3:0] ahb_prot_t;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'd0,
    HRESP_ERROR = 2'd1,
    HRESP_RETRY = 2'd2,
    HRESP_SPLIT = 2'd3
  } ahb_resp_t;

endpackage

interface ahb_sram_slave_if
  import ahb_sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();

  logic                  hsel;
  logic [ADDR_WIDTH-1:0] haddr;
  ahb_trans_t            htrans;
  logic                  hwrite;
  ahb_size_t             hsize;
  ahb_burst_t            hburst;
  ahb_prot_t             hprot;
  logic [DATA_WIDTH-1:0] hwdata;
  logic                  hreadyin;
  logic [DATA_WIDTH-1:0] hrdata;
  logic                  hready;
  ahb_resp_t             hresp;

  // hreadyin comes from the slave-side multiplexor, not the master
  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
    input  hreadyin, hrdata, hready, hresp
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hreadyin,
    output hrdata, hready, hresp
  );

endinterface
`default_nettype wire

// File: rtl/ahb_sram_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ahb_sram_slave                                         |
// | Description : AHB slave backed by a word-addressed memory. Byte,     |
// |               halfword and word accesses, programmable wait states,  |
// |               two-cycle ERROR response for illegal transfers.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+

module ahb_sram_slave
  import ahb_sram_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input logic               hclk,
  input logic               hresetn,
  ahb_sram_slave_if.slave   bus
);

  localparam int NBYTES    = DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(NBYTES);
  localparam int LB_W      = LANE_BITS + 1;
  localparam int IDX_WIDTH = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CNT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   wcnt_q, wcnt_d;
  logic                   pend_q, pend_d;
  logic [ADDR_WIDTH-1:0]  a_q, a_d;
  logic                   w_q, w_d;
  ahb_size_t              s_q, s_d;
  logic [DATA_WIDTH-1:0]  hrdata_q, hrdata_d;
  logic                   hready_q, hready_d;
  ahb_resp_t              hresp_q, hresp_d;

  logic [DATA_WIDTH-1:0]  mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0]  mem_d;

  logic                   addr_valid;
  logic                   size_bad;
  logic                   misalign;
  logic                   range_bad;
  logic                   illegal;
  logic [2:0]             align_mask;
  logic [ADDR_WIDTH-1:0]  word_addr;

  logic [IDX_WIDTH-1:0]   a_idx;
  logic [IDX_WIDTH-1:0]   h_idx;
  logic [IDX_WIDTH-1:0]   rd_idx;
  logic                   rd_load;
  logic                   wr_en;

  logic [LB_W-1:0]        lane_lo;
  logic [LB_W-1:0]        lane_hi;
  logic [NBYTES-1:0]      be;

  logic                   unused_ok;

  // ------------------------------------------------------------------
  // Address-phase decode. Only NONSEQ/SEQ with the bus ready counts as
  // a transfer; everything else yields a zero-wait OKAY data phase.
  // ------------------------------------------------------------------
  assign addr_valid = bus.hsel & bus.hreadyin &
                      ((bus.htrans == HTRANS_NONSEQ) | (bus.htrans == HTRANS_SEQ));

  assign size_bad   = (int'(bus.hsize) > LANE_BITS);
  // hsize=3 wraps the shift to zero, so the mask becomes 3'b111 (8-byte)
  assign align_mask = (3'b001 << bus.hsize) - 3'b001;
  assign misalign   = |(bus.haddr[2:0] & align_mask);
  assign word_addr  = bus.haddr >> LANE_BITS;
  assign range_bad  = (word_addr >= ADDR_WIDTH'(MEM_DEPTH));
  assign illegal    = size_bad | misalign | range_bad;

  assign a_idx = a_q[LANE_BITS +: IDX_WIDTH];
  assign h_idx = bus.haddr[LANE_BITS +: IDX_WIDTH];

  // Little-endian lane window [lane_lo, lane_hi) of the data-phase access
  assign lane_lo = LB_W'(a_q[LANE_BITS-1:0]);
  assign lane_hi = lane_lo + (LB_W'(1) << s_q);

  generate
    for (genvar i = 0; i < NBYTES; i++) begin : g_lane
      assign be[i] = (LB_W'(i) >= lane_lo) && (LB_W'(i) < lane_hi);
      // Merged post-write word: selected lanes from hwdata, rest kept
      assign mem_d[8*i +: 8] = be[i] ? bus.hwdata[8*i +: 8] : mem_q[a_idx][8*i +: 8];
    end
  endgenerate

  // Burst/protection fields carry no meaning for this slave
  assign unused_ok = ^{bus.hburst, bus.hprot, a_q};

  // Next-state, address capture and read-load decisions
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    pend_d  = pend_q;
    a_d     = a_q;
    w_d     = w_q;
    s_d     = s_q;
    rd_load = 1'b0;
    rd_idx  = a_idx;
    // A legal transfer completes in the IDLE cycle that follows its
    // address phase (or its last wait cycle); writes commit on that edge.
    wr_en   = (state_q == ST_IDLE) && pend_q && w_q;

    case (state_q)
      ST_IDLE, ST_ERR2: begin
        // Any pending transfer completes here; a new one may pipeline in
        pend_d  = 1'b0;
        state_d = ST_IDLE;
        if (addr_valid) begin
          a_d = bus.haddr;
          w_d = bus.hwrite;
          s_d = bus.hsize;
          if (illegal) begin
            state_d = ST_ERR1;
          end else begin
            pend_d = 1'b1;
            if (WAIT_STATES > 0) begin
              state_d = ST_WAIT;
              wcnt_d  = CNT_WIDTH'(WAIT_STATES - 1);
            end else begin
              rd_load = !bus.hwrite;
              rd_idx  = h_idx;
            end
          end
        end
      end
      ST_WAIT: begin
        if (wcnt_q == '0) begin
          state_d = ST_IDLE;
          rd_load = !w_q;
        end else begin
          wcnt_d = wcnt_q - CNT_WIDTH'(1);
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Read data register; a same-edge write to the same word is forwarded
  always_comb begin
    hrdata_d = hrdata_q;
    if (rd_load) begin
      hrdata_d = (wr_en && (rd_idx == a_idx)) ? mem_d : mem_q[rd_idx];
    end
  end

  // Bus response flops follow the state being entered
  always_comb begin
    hready_d = (state_d == ST_IDLE) || (state_d == ST_ERR2);
    hresp_d  = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  end

  // Control and output registers, cleared immediately on reset
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q  <= ST_IDLE;
      wcnt_q   <= '0;
      pend_q   <= 1'b0;
      a_q      <= '0;
      w_q      <= 1'b0;
      s_q      <= HSIZE_BYTE;
      hrdata_q <= '0;
      hready_q <= 1'b1;
      hresp_q  <= HRESP_OKAY;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      pend_q   <= pend_d;
      a_q      <= a_d;
      w_q      <= w_d;
      s_q      <= s_d;
      hrdata_q <= hrdata_d;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
    end
  end

  // Storage array; contents deliberately survive reset
  always_ff @(posedge hclk) begin
    if (wr_en) begin
      mem_q[a_idx] <= mem_d;
    end
  end

  assign bus.hrdata = hrdata_q;
  assign bus.hready = hready_q;
  assign bus.hresp  = hresp_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_ahb_sram_slave                                      |
// | Description : Three ahb_sram_slave instances (0, 2 and 3 wait        |
// |               states) on one AHB bus with a slave-side mux; random   |
// |               and directed transfers checked against a memory model. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+

module tb_ahb_sram_slave;
  import ahb_sram_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 256;
  localparam int NSLV  = 3;
  localparam int NONE  = 3;

  typedef struct {
    int         tgt;
    ahb_trans_t trans;
    logic       wr;
    ahb_size_t  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } xfer_t;

  logic hclk = 1'b0;
  logic hresetn;
  always #5 hclk = ~hclk;

  // Master-side drive
  logic        m_hsel;
  int          m_tgt;
  logic [31:0] m_haddr;
  ahb_trans_t  m_htrans;
  logic        m_hwrite;
  ahb_size_t   m_hsize;
  logic [31:0] m_hwdata;

  // Slave-side mux
  logic        s_hready [NSLV];
  logic [31:0] s_hrdata [NSLV];
  ahb_resp_t   s_hresp  [NSLV];
  logic [1:0]  dsel;
  logic        bus_hready;
  logic [31:0] bus_hrdata;
  ahb_resp_t   bus_hresp;

  generate
    for (genvar g = 0; g < NSLV; g++) begin : g_slv
      localparam int WS = (g == 0) ? 0 : (g == 1) ? 2 : 3;
      ahb_sram_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
      assign bus.hsel     = m_hsel && (m_tgt == g);
      assign bus.haddr    = m_haddr;
      assign bus.htrans   = m_htrans;
      assign bus.hwrite   = m_hwrite;
      assign bus.hsize    = m_hsize;
      assign bus.hburst   = 3'b000;
      assign bus.hprot    = 4'b0011;
      assign bus.hwdata   = m_hwdata;
      assign bus.hreadyin = bus_hready;
      assign s_hready[g]  = bus.hready;
      assign s_hrdata[g]  = bus.hrdata;
      assign s_hresp[g]   = bus.hresp;
      ahb_sram_slave #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MEM_DEPTH  (DEPTH),
        .WAIT_STATES(WS)
      ) u_dut (
        .hclk   (hclk),
        .hresetn(hresetn),
        .bus    (bus)
      );
    end
  endgenerate

  always_comb begin
    bus_hready = 1'b1;
    bus_hrdata = '0;
    bus_hresp  = HRESP_OKAY;
    for (int k = 0; k < NSLV; k++) begin
      if (int'(dsel) == k) begin
        bus_hready = s_hready[k];
        bus_hrdata = s_hrdata[k];
        bus_hresp  = s_hresp[k];
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn)        dsel <= 2'd3;
    else if (bus_hready) dsel <= (m_hsel && m_tgt < NSLV) ? 2'(m_tgt) : 2'd3;
  end

  // Reference model
  logic [31:0] ref_mem [NSLV][DEPTH];
  logic [31:0] last_rdata;
  xfer_t       txq [$];
  int          n_vec  = 0;
  int          n_miss = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int ws_of(input int t);
    return (t == 0) ? 0 : (t == 1) ? 2 : 3;
  endfunction

  function automatic xfer_t mk(input int t, input ahb_trans_t tr, input logic wr,
                               input ahb_size_t sz, input logic [31:0] a, input logic [31:0] d);
    xfer_t x;
    x.tgt = t; x.trans = tr; x.wr = wr; x.size = sz; x.addr = a; x.wdata = d;
    return x;
  endfunction

  function automatic bit is_active(input xfer_t x);
    return (x.tgt < NSLV) && (x.trans == HTRANS_NONSEQ || x.trans == HTRANS_SEQ);
  endfunction

  function automatic bit is_legal(input xfer_t x);
    int nb;
    nb = 1 << int'(x.size);
    return (int'(x.size) <= 2) && ((int'(x.addr) % nb) == 0) && ((x.addr / 4) < DEPTH);
  endfunction

  task automatic model_write(input xfer_t x);
    int idx;
    int nb;
    int lane;
    logic [31:0] w;
    idx = int'(x.addr / 4);
    nb  = 1 << int'(x.size);
    w   = ref_mem[x.tgt][idx];
    for (int b = 0; b < nb; b++) begin
      lane = int'(x.addr % 4) + b;
      w[lane*8 +: 8] = x.wdata[lane*8 +: 8];
    end
    ref_mem[x.tgt][idx] = w;
  endtask

  task automatic drive_addr(input xfer_t x);
    m_hsel   = (x.tgt < NSLV);
    m_tgt    = x.tgt;
    m_htrans = x.trans;
    m_haddr  = x.addr;
    m_hwrite = x.wr;
    m_hsize  = x.size;
  endtask

  // Observe one data phase (called at a falling edge) until hready
  task automatic finish_data(input xfer_t x);
    int   k;
    bit   done;
    bit   act;
    bit   lg;
    int   ws;
    logic er;
    ahb_resp_t eresp;
    k = 0; done = 0;
    act = is_active(x); lg = is_legal(x); ws = ws_of(x.tgt);
    while (!done) begin
      if (!act)     begin er = 1'b1;      eresp = HRESP_OKAY;  end
      else if (lg)  begin er = (k >= ws); eresp = HRESP_OKAY;  end
      else          begin er = (k >= 1);  eresp = HRESP_ERROR; end
      check_eq($sformatf("hready s%0d k%0d", x.tgt, k), 32'(bus_hready), 32'(er));
      check_eq($sformatf("hresp s%0d k%0d", x.tgt, k), 32'(bus_hresp), 32'(eresp));
      if (bus_hready) begin
        done = 1;
      end else if (k >= 20) begin
        check_eq("data_phase_timeout", 32'(bus_hready), 32'd1);
        done = 1;
      end else begin
        @(negedge hclk);
        k++;
      end
    end
    if (act && lg && bus_hready) begin
      if (x.wr) begin
        model_write(x);
      end else begin
        check_eq($sformatf("rdata s%0d a%h", x.tgt, x.addr), bus_hrdata, ref_mem[x.tgt][x.addr / 4]);
        last_rdata = bus_hrdata;
      end
    end
  endtask

  // Pipelined master: address of next overlaps data phase of current
  task automatic run_queue();
    xfer_t cur;
    xfer_t nxt;
    xfer_t idle;
    idle = mk(NONE, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0, 32'h0);
    cur  = idle;
    while (txq.size() > 0) begin
      nxt = txq.pop_front();
      drive_addr(nxt);
      m_hwdata = cur.wdata;
      finish_data(cur);
      @(posedge hclk);
      cur = nxt;
      @(negedge hclk);
    end
    drive_addr(idle);
    m_hwdata = cur.wdata;
    finish_data(cur);
    @(posedge hclk);
    @(negedge hclk);
  endtask

  function automatic xfer_t rand_xfer();
    int r;
    int t;
    int word;
    int off;
    ahb_trans_t tr;
    ahb_size_t  sz;
    logic [31:0] a;
    r  = $urandom_range(0, 9);
    t  = (r < 3) ? 0 : (r < 6) ? 1 : (r < 8) ? 2 : NONE;
    r  = $urandom_range(0, 9);
    tr = (r < 4) ? HTRANS_NONSEQ : (r < 8) ? HTRANS_SEQ : (r == 8) ? HTRANS_IDLE : HTRANS_BUSY;
    sz = ($urandom_range(0, 9) == 0) ? HSIZE_DWORD : ahb_size_t'($urandom_range(0, 2));
    word = $urandom_range(0, 15);
    if ($urandom_range(0, 9) == 0) off = $urandom_range(0, 3);
    else                           off = ($urandom_range(0, 3) >> int'(sz)) << int'(sz);
    a = 32'(word * 4 + (off % 4));
    if ($urandom_range(0, 19) == 0) a = 32'(DEPTH * 4 + word * 4);
    return mk(t, tr, 1'($urandom_range(0, 1)), sz, a, $urandom);
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    hresetn  = 1'b0;
    drive_addr(mk(NONE, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0, 32'h0));
    m_hwdata = '0;
    last_rdata = '0;
    repeat (3) @(negedge hclk);
    for (int s = 0; s < NSLV; s++) begin
      check_eq($sformatf("reset hready s%0d", s), 32'(s_hready[s]), 32'd1);
      check_eq($sformatf("reset hresp s%0d", s),  32'(s_hresp[s]),  32'(HRESP_OKAY));
      check_eq($sformatf("reset hrdata s%0d", s), s_hrdata[s],      32'h0);
    end
    hresetn = 1'b1;
    @(negedge hclk);

    // Known contents for the words the traffic touches
    for (int s = 0; s < NSLV; s++)
      for (int w = 0; w < 16; w++)
        txq.push_back(mk(s, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'(w * 4), $urandom));
    run_queue();

    // Back-to-back write then read of the same word, zero wait states
    txq.push_back(mk(0, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10, 32'hDEADBEEF));
    txq.push_back(mk(0, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10, 32'h0));
    run_queue();
    check_eq("wr_then_rd", last_rdata, 32'hDEADBEEF);

    // Byte and halfword lane writes
    txq.push_back(mk(0, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'h12, 32'h0055_0000));
    txq.push_back(mk(0, HTRANS_SEQ,    1'b1, HSIZE_HALF, 32'h10, 32'h0000_A5A5));
    txq.push_back(mk(0, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10, 32'h0));
    run_queue();
    check_eq("byte_lanes", last_rdata, 32'hDE55A5A5);

    // Wait-state read, errors, service in ERR2, idle/busy/deselected
    txq.push_back(mk(1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10, 32'h0));
    txq.push_back(mk(1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h02, 32'h1111_1111));
    txq.push_back(mk(0, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'(DEPTH * 4), 32'h2222_2222));
    txq.push_back(mk(0, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10, 32'h0));
    txq.push_back(mk(NONE, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h10, 32'h3333_3333));
    txq.push_back(mk(0, HTRANS_BUSY,   1'b1, HSIZE_WORD, 32'h10, 32'h4444_4444));
    txq.push_back(mk(0, HTRANS_IDLE,   1'b1, HSIZE_WORD, 32'h10, 32'h5555_5555));
    txq.push_back(mk(0, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h10, 32'h0));
    txq.push_back(mk(1, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h00, 32'h0));
    run_queue();

    // Random pipelined traffic across all slaves
    for (int n = 0; n < 400; n++) txq.push_back(rand_xfer());
    run_queue();

    // Reset in the middle of a wait-stated write on the 3-wait slave
    drive_addr(mk(2, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h14, 32'h0));
    @(posedge hclk);
    @(negedge hclk);
    drive_addr(mk(NONE, HTRANS_IDLE, 1'b0, HSIZE_WORD, 32'h0, 32'h0));
    m_hwdata = 32'hCAFEF00D;
    check_eq("pre_reset_wait", 32'(bus_hready), 32'd0);
    #2 hresetn = 1'b0;
    #1;
    check_eq("mid_reset hready", 32'(s_hready[2]), 32'd1);
    check_eq("mid_reset hresp",  32'(s_hresp[2]),  32'(HRESP_OKAY));
    check_eq("mid_reset hrdata", s_hrdata[2],      32'h0);
    @(negedge hclk);
    hresetn = 1'b1;
    @(negedge hclk);
    txq.push_back(mk(2, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h14, 32'h0));
    run_queue();
    check_eq("write_discarded", last_rdata, ref_mem[2][5]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
